// File: rtl/generador_onda_cuadrada.sv
// Square-wave generator with period/high-time shadow registers and a three-state FSM.
// Optional period counter on num_periodos, enabled by defining CONTADOR_PERIODOS_EN.
module generador_onda_cuadrada #(
  parameter int ANCHO = 16
) (
  input  logic             clock_FPGA,
  input  logic             reset,
  input  logic             habilitar,
  input  logic             cargar,
  input  logic [ANCHO-1:0] periodo,
  input  logic [ANCHO-1:0] ancho_alto,
  output logic             onda_cuadrada,
  output logic             flanco_pos,
  output logic             ocupado,
  output logic             error_config,
  output logic [15:0]      num_periodos
);

  typedef enum logic [1:0] {IDLE, ALTO, BAJO} estado_t;

  estado_t          estado, estado_sig;
  logic [ANCHO-1:0] contador, contador_sig;
  logic [ANCHO-1:0] p_s, h_s, p_pend, h_pend, p_ef, h_ef;
  logic             cfg_cargada, cfg_valida, carga_ok, cargar_sombra, ultimo_bajo;

  assign cfg_valida  = (periodo >= ANCHO'(2)) && (ancho_alto != '0) && (ancho_alto < periodo);
  assign carga_ok    = cargar && cfg_valida;
  // A valid load in the same cycle as a period start governs that period directly.
  assign p_ef        = carga_ok ? periodo    : p_pend;
  assign h_ef        = carga_ok ? ancho_alto : h_pend;
  assign ultimo_bajo = (estado == BAJO) && (contador == p_s - ANCHO'(1));

  always_comb begin
    estado_sig    = estado;
    contador_sig  = contador;
    cargar_sombra = 1'b0;
    case (estado)
      IDLE: begin
        contador_sig = '0;
        if (habilitar && (cfg_cargada || carga_ok)) begin
          estado_sig    = ALTO;
          cargar_sombra = 1'b1;
        end
      end
      ALTO: begin
        contador_sig = contador + ANCHO'(1);
        if (contador == h_s - ANCHO'(1)) estado_sig = BAJO;
      end
      BAJO: begin
        if (ultimo_bajo) begin
          contador_sig = '0;
          if (habilitar) begin
            estado_sig    = ALTO;
            cargar_sombra = 1'b1;
          end else begin
            estado_sig = IDLE;
          end
        end else begin
          contador_sig = contador + ANCHO'(1);
        end
      end
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clock_FPGA or posedge reset) begin
    if (reset) begin
      estado   <= IDLE;
      contador <= '0;
      p_s      <= '0;
      h_s      <= '0;
    end else begin
      estado   <= estado_sig;
      contador <= contador_sig;
      if (cargar_sombra) begin
        p_s <= p_ef;
        h_s <= h_ef;
      end
    end
  end

  // Invalid loads only raise the sticky error; the pending values are kept.
  always_ff @(posedge clock_FPGA or posedge reset) begin
    if (reset) begin
      p_pend       <= '0;
      h_pend       <= '0;
      cfg_cargada  <= 1'b0;
      error_config <= 1'b0;
    end else if (cargar) begin
      if (cfg_valida) begin
        p_pend       <= periodo;
        h_pend       <= ancho_alto;
        cfg_cargada  <= 1'b1;
        error_config <= 1'b0;
      end else begin
        error_config <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_FPGA or posedge reset) begin
    if (reset) begin
      onda_cuadrada <= 1'b0;
      flanco_pos    <= 1'b0;
      ocupado       <= 1'b0;
    end else begin
      onda_cuadrada <= (estado_sig == ALTO);
      flanco_pos    <= (estado_sig == ALTO) && (estado != ALTO);
      ocupado       <= (estado_sig != IDLE);
    end
  end

`ifdef CONTADOR_PERIODOS_EN
  always_ff @(posedge clock_FPGA or posedge reset) begin
    if (reset) num_periodos <= '0;
    else if (ultimo_bajo) num_periodos <= num_periodos + 16'd1;
  end
`else
  assign num_periodos = '0;
`endif

endmodule
